addr_bus_arbiter: RTL and testbench

ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

---
 rtl/addr_bus_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/addr_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_addr_bus_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addr_bus_pkg.sv
// Shared types and default constants for the address-bus arbiter and the
// addressable targets it drives.
package addr_bus_pkg;

    typedef enum logic [1:0] {
        READ         = 2'd0,
        WRITE        = 2'd1,
        READ_N_WRITE = 2'd2
    } ADDRESSED_DIRECTION;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ        = 2;
    localparam int DEFAULT_ADDRESS_WIDTH  = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the search starts at i_ptr and wraps,
// the first requesting index found wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Round-robin address-bus arbiter: grants one requester at a time, issues a
// registered read or write strobe and waits for the matching ack or a timeout.
module addr_bus_arbiter
    import addr_bus_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ-1:0]               req_write,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_done,
    output logic [NUM_REQ-1:0]               resp_error,
    output logic [ADDRESS_WIDTH-1:0]         active_address,
    output logic                             read_enable_in,
    output logic                             write_enable_in,
    input  logic                             read_enable_out,
    input  logic                             write_enable_out,
    output logic                             busy
);

    localparam int         PTR_W        = $clog2(NUM_REQ);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t         r_state;
    ADDRESSED_DIRECTION r_dir;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [7:0]         r_wait;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic               r_rd_en;
    logic               r_wr_en;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_error;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_accept;
    logic               w_ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    // Grants are offered only in IDLE, and never while reset is held.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_accept   = |(req_valid & req_ready);
    assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    assign w_ack      = (r_dir == WRITE) ? write_enable_out : read_enable_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dir     <= READ;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_wait    <= '0;
            r_address <= '0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= '0;
            r_error   <= '0;
        end else begin
            r_done  <= '0;
            r_error <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner   <= w_grant_idx;
                        r_address <= req_address[w_grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        r_dir     <= req_write[w_grant_idx] ? WRITE : READ;
                        r_rd_en   <= !req_write[w_grant_idx];
                        r_wr_en   <= req_write[w_grant_idx];
                        r_wait    <= '0;
                        r_ptr     <= w_next_ptr;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An ack on the final wait cycle still completes cleanly.
                    if (w_ack || r_wait == TIMEOUT_LAST) begin
                        r_rd_en          <= 1'b0;
                        r_wr_en          <= 1'b0;
                        r_done[r_owner]  <= 1'b1;
                        r_error[r_owner] <= !w_ack;
                        r_state          <= DONE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign active_address  = r_address;
    assign read_enable_in  = r_rd_en;
    assign write_enable_in = r_wr_en;
    assign resp_done       = r_done;
    assign resp_error      = r_error;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter: single read, timeout, wrong-type ack,
// reset mid-transaction and two-requester contention.
module tb_addr_bus_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*AW-1:0] req_address = '0;
    logic [NR-1:0] req_write = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] resp_done;
    logic [NR-1:0] resp_error;
    logic [AW-1:0] active_address;
    logic          read_enable_in;
    logic          write_enable_in;
    logic          read_enable_out = 1'b0;
    logic          write_enable_out = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    addr_bus_arbiter #(
        .NUM_REQ        (NR),
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_address      (req_address),
        .req_write        (req_write),
        .req_ready        (req_ready),
        .resp_done        (resp_done),
        .resp_error       (resp_error),
        .active_address   (active_address),
        .read_enable_in   (read_enable_in),
        .write_enable_in  (write_enable_in),
        .read_enable_out  (read_enable_out),
        .write_enable_out (write_enable_out),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR*AW-1:0] addr, input logic [NR-1:0] wr);
        req_valid   = valid;
        req_address = addr;
        req_write   = wr;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expGrant;

        // Reset asserted between clock edges, with requests pending.
        req_valid = 2'b11;
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_addr", 32'(active_address), 32'h0);
        checkOutput("rst_strobes", 32'({read_enable_in, write_enable_in}), 32'h0);
        checkOutput("rst_done", 32'({resp_done, resp_error}), 32'h0);
        stepClock();
        applyStimulus(2'b00, 8'h00, 2'b00);
        rst = 1'b0;
        stepClock();

        // Single read: requester 0, address 0x5, ack in the second ISSUE cycle.
        applyStimulus(2'b01, 8'h05, 2'b00);
        checkOutput("rd_ready", 32'(req_ready), 32'h1);
        stepClock();
        applyStimulus(2'b00, 8'h00, 2'b00);
        checkOutput("rd_issue1_rd", 32'(read_enable_in), 32'h1);
        checkOutput("rd_issue1_wr", 32'(write_enable_in), 32'h0);
        checkOutput("rd_issue1_addr", 32'(active_address), 32'h5);
        checkOutput("rd_issue1_busy", 32'(busy), 32'h1);
        checkOutput("rd_issue1_ready", 32'(req_ready), 32'h0);
        stepClock();
        checkOutput("rd_issue2_rd", 32'(read_enable_in), 32'h1);
        read_enable_out = 1'b1;
        stepClock();
        read_enable_out = 1'b0;
        checkOutput("rd_done_rd", 32'(read_enable_in), 32'h0);
        checkOutput("rd_done_pulse", 32'(resp_done), 32'h1);
        checkOutput("rd_done_err", 32'(resp_error), 32'h0);
        checkOutput("rd_done_busy", 32'(busy), 32'h1);
        stepClock();
        checkOutput("rd_idle_done", 32'(resp_done), 32'h0);
        checkOutput("rd_idle_busy", 32'(busy), 32'h0);
        checkOutput("rd_idle_addr", 32'(active_address), 32'h5);

        // Timeout: requester 1 writes 0xA, no ack; pointer now favours 1.
        applyStimulus(2'b10, 8'hA0, 2'b10);
        checkOutput("to_ready", 32'(req_ready), 32'h2);
        stepClock();
        applyStimulus(2'b00, 8'h00, 2'b00);
        for (int k = 0; k < TO; k++) begin
            checkOutput("to_wr_strobe", 32'(write_enable_in), 32'h1);
            checkOutput("to_rd_strobe", 32'(read_enable_in), 32'h0);
            checkOutput("to_addr", 32'(active_address), 32'hA);
            checkOutput("to_no_done", 32'(resp_done), 32'h0);
            stepClock();
        end
        checkOutput("to_done_wr", 32'(write_enable_in), 32'h0);
        checkOutput("to_done_pulse", 32'(resp_done), 32'h2);
        checkOutput("to_done_err", 32'(resp_error), 32'h2);
        stepClock();
        checkOutput("to_idle_done", 32'(resp_done), 32'h0);

        // Read from requester 0: write ack held (ignored), read ack on timeout cycle.
        applyStimulus(2'b01, 8'h03, 2'b00);
        checkOutput("wa_ready", 32'(req_ready), 32'h1);
        stepClock();
        applyStimulus(2'b00, 8'h00, 2'b00);
        write_enable_out = 1'b1;
        for (int k = 0; k < TO; k++) begin
            checkOutput("wa_rd_strobe", 32'(read_enable_in), 32'h1);
            checkOutput("wa_wr_strobe", 32'(write_enable_in), 32'h0);
            if (k == TO - 1) begin
                read_enable_out = 1'b1;
            end
            stepClock();
        end
        read_enable_out  = 1'b0;
        write_enable_out = 1'b0;
        checkOutput("wa_done_pulse", 32'(resp_done), 32'h1);
        checkOutput("wa_done_err", 32'(resp_error), 32'h0);
        checkOutput("wa_done_rd", 32'(read_enable_in), 32'h0);
        stepClock();

        // Reset pulse during a write strobe from requester 1.
        applyStimulus(2'b10, 8'hC0, 2'b10);
        checkOutput("rs_ready", 32'(req_ready), 32'h2);
        stepClock();
        applyStimulus(2'b00, 8'h00, 2'b00);
        checkOutput("rs_wr_strobe", 32'(write_enable_in), 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rs_strobe_drop", 32'(write_enable_in), 32'h0);
        checkOutput("rs_busy", 32'(busy), 32'h0);
        checkOutput("rs_addr", 32'(active_address), 32'h0);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepClock();
            checkOutput("rs_no_done", 32'(resp_done), 32'h0);
        end

        // Contention: both requesters read continuously, target always acks.
        read_enable_out = 1'b1;
        applyStimulus(2'b11, 8'h96, 2'b00);
        for (int c = 0; c < 12; c++) begin
            expGrant = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
            checkOutput("ct_onehot", 32'($countones(req_ready) <= 1), 32'h1);
            case (c % 3)
                0: begin
                    checkOutput("ct_grant", 32'(req_ready), 32'(expGrant));
                    checkOutput("ct_idle_busy", 32'(busy), 32'h0);
                end
                1: begin
                    checkOutput("ct_issue_ready", 32'(req_ready), 32'h0);
                    checkOutput("ct_issue_rd", 32'(read_enable_in), 32'h1);
                    checkOutput("ct_issue_addr", 32'(active_address), expGrant[0] ? 32'h6 : 32'h9);
                end
                default: begin
                    checkOutput("ct_done_ready", 32'(req_ready), 32'h0);
                    checkOutput("ct_done_pulse", 32'(resp_done), 32'(expGrant));
                    checkOutput("ct_done_err", 32'(resp_error), 32'h0);
                end
            endcase
            stepClock();
        end
        read_enable_out = 1'b0;
        applyStimulus(2'b00, 8'h00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
